uldl_slot_scheduler: RTL
========================

# uldl_slot_scheduler

TDMA slot scheduler for the satellite IoT traffic path. It queues uplink and downlink packet IDs produced by `traffic_uldl_core` in two small FIFOs. It splits a fixed-length frame into DL and UL slots and offers at most one packet per slot to the downstream transmitter through a valid/ready handshake. It sits between the traffic core and the TX/modulator stage.

## Interface
Parameters:
- `SLOTS` = 8: slots per frame, power of two.
- `SLOT_CYC` = 16: clock cycles per slot, ≥ 4.
- `QDEPTH` = 4: entries per direction FIFO, power of two.
- `ID_W` = 8: packet-ID width.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_ena`, in, 1: scheduling enable; low freezes slot timing.
- `i_pkt_valid`, in, 1: one-cycle packet pulse (core `o_packet_pulse`).
- `i_pkt_id`, in, `ID_W`: packet ID.
- `i_pkt_dir_dl`, in, 1: 1 = DL queue, 0 = UL queue.
- `i_dl_slots`, in, log2(`SLOTS`)+1: number of DL slots at frame start.
- `o_tx_valid`, out, 1: packet offered.
- `i_tx_ready`, in, 1: downstream accepts.
- `o_tx_id`, out, `ID_W`: offered ID.
- `o_tx_dir_dl`, out, 1: direction of the current slot.
- `o_slot_idx`, out, log2(`SLOTS`): current slot index.
- `o_frame_start`, out, 1: pulse in cycle 0 of slot 0.
- `o_ul_drop`, `o_dl_drop`, out, 1: one-cycle pulse when a push hits a full queue.
- `o_ul_level`, `o_dl_level`, out, log2(`QDEPTH`)+1: queue occupancy.

## Operation
- **Reset values:** all outputs 0; queues empty; slot index 0; cycle counter 0; latched DL split 0; FSM in IDLE.
- **FSM: IDLE → RUN.**
  - IDLE → RUN on the first cycle with `i_ena`=1.
  - RUN → IDLE is only through reset.
  - `i_ena`=0 in RUN holds the cycle counter, slot index and `o_tx_valid`/`o_tx_id`. Handshakes are still honoured.
- **Queues:**
  - Pushes are accepted in any state, including IDLE and `i_ena`=0.
  - A push into a full queue is discarded and pulses the drop flag the next cycle.
  - A pop of the same queue in the same cycle as a push with count == `QDEPTH` is not a drop: the push succeeds and the count is unchanged.
- **Frame split:**
  - `i_dl_slots` is sampled at cycle 0 of slot 0 into `dl_lat`.
  - Values > `SLOTS` saturate to `SLOTS`.
  - Slot s is DL when s < `dl_lat`, otherwise UL.
  - `o_tx_dir_dl` reflects this for the whole slot.
- **Per slot:**
  - Cycle 0 is a guard cycle: `o_tx_valid`=0.
  - In cycles 1..`SLOT_CYC`-1, `o_tx_valid`=1 whenever the slot's queue is non-empty and the slot is not yet served. `o_tx_id` is the queue head.
  - A handshake (`o_tx_valid` & `i_tx_ready`) pops the head and marks the slot served. Maximum one transfer per slot.
  - If the slot ends without a handshake, the head is retained, not popped.
- **Slot and frame advance:**
  - The slot index wraps `SLOTS`-1 → 0.
  - `o_frame_start` pulses in cycle 0 of slot 0, including the first slot after leaving IDLE.

## Timing
- All outputs are registered.
- **Push latency:** a push in cycle t is visible in the level outputs at t+1. It is offerable from t+1 if t+1 lies in the window of the matching slot and that slot is unserved.
- **Handshake:** `o_tx_valid` drops in the cycle after the handshake. A handshake in the last slot cycle counts; the next cycle is the guard cycle.
- **Valid/data stability:** `o_tx_id` is stable while `o_tx_valid`=1 without `i_tx_ready`. Pushes to a non-empty queue never change the head.
- **Frame length:** `SLOTS`·`SLOT_CYC` enabled cycles.
- **Reset mid-slot:** asynchronous clear. An offered packet is lost and the queues are emptied.

## Structure
- **Shared package `uldl_sched_pkg`:**
  - FSM state enum (IDLE, RUN).
  - Direction constants DIR_UL=0, DIR_DL=1.
  - Default parameter constants.
- **Sub-module `uldl_id_fifo`:**
  - Parameterised by `ID_W` and `QDEPTH`.
  - Ports: push, pop, head, count, full, empty; pop-before-push ordering.
  - Instantiated twice (UL, DL).
- The top holds the slot/cycle counters, `dl_lat`, the served flag and the offer logic.

## Test plan
- Reset, then `i_ena`=1 with `i_dl_slots`=3 and both queues empty → `o_frame_start` every 128 cycles; `o_tx_dir_dl`=1 for slots 0–2 and 0 for slots 3–7; `o_tx_valid` never 1.
- Push DL IDs 0x11, 0x22 before slot 0 with `i_tx_ready`=1 → 0x11 accepted in cycle 1 of slot 0 and 0x22 in cycle 1 of slot 1; `o_dl_level` goes 2→1→0.
- Push UL ID 0x5A with `i_tx_ready`=0 through all of slot 3 → valid held with ID 0x5A for cycles 1–15 and dropped at cycle 0 of slot 4; ID 0x5A is still the head and is accepted in slot 4 when ready=1.
- Push 5 UL packets back-to-back into an empty queue → level 4 and one `o_ul_drop` pulse on the 5th push; push plus pop at full → no drop.
- Change `i_dl_slots` from 2 to 9 mid-frame → split changes only at the next slot 0, then saturates to 8 (all slots DL).
- Drop `i_ena` for 20 cycles while valid and assert `i_rst` mid-slot → counters and offer frozen during `i_ena`=0; after reset all outputs are 0 and both levels are 0.

Source files
------------

// File: rtl/uldl_sched_pkg.sv
// Shared types and defaults for the UL/DL TDMA slot scheduler.
package uldl_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam logic DIR_UL = 1'b0;
  localparam logic DIR_DL = 1'b1;

  localparam int DEF_SLOTS    = 8;
  localparam int DEF_SLOT_CYC = 16;
  localparam int DEF_QDEPTH   = 4;
  localparam int DEF_ID_W     = 8;

endpackage

// File: rtl/uldl_id_fifo.sv
// Small packet-ID FIFO with pop-before-push ordering; exposes next-cycle head/count
// so the scheduler can register its offer without an extra cycle of latency.
module uldl_id_fifo #(
  parameter int ID_W   = 8,
  parameter int QDEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [ID_W-1:0]          i_push_id,
  input  logic                     i_pop,
  output logic [ID_W-1:0]          o_head,
  output logic [ID_W-1:0]          o_head_nxt,
  output logic [$clog2(QDEPTH):0]  o_count,
  output logic [$clog2(QDEPTH):0]  o_count_nxt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [ID_W-1:0] mem_q [QDEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_ok, push_ok;

  // Pointer and occupancy update; a push into a full queue is allowed only when a pop frees the slot.
  always_comb begin
    pop_ok      = i_pop && (count_q != '0);
    push_ok     = i_push && ((count_q != FULL_CNT) || pop_ok);
    rd_d        = rd_q + AW'(pop_ok);
    wr_d        = wr_q + AW'(push_ok);
    count_d     = count_q + CW'(push_ok) - CW'(pop_ok);
    o_head_nxt  = (push_ok && (wr_q == rd_d)) ? i_push_id : mem_q[rd_d];
  end

  assign o_head      = mem_q[rd_q];
  assign o_count     = count_q;
  assign o_count_nxt = count_d;
  assign o_full      = (count_q == FULL_CNT);
  assign o_empty     = (count_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_q] <= i_push_id;
      end
    end
  end

endmodule

// File: rtl/uldl_slot_scheduler.sv
// TDMA slot scheduler: splits each frame into DL then UL slots and offers at most one
// queued packet ID per slot over a valid/ready handshake.
module uldl_slot_scheduler
  import uldl_sched_pkg::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int QDEPTH   = DEF_QDEPTH,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ena,
  input  logic                     i_pkt_valid,
  input  logic [ID_W-1:0]          i_pkt_id,
  input  logic                     i_pkt_dir_dl,
  input  logic [$clog2(SLOTS):0]   i_dl_slots,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [ID_W-1:0]          o_tx_id,
  output logic                     o_tx_dir_dl,
  output logic [$clog2(SLOTS)-1:0] o_slot_idx,
  output logic                     o_frame_start,
  output logic                     o_ul_drop,
  output logic                     o_dl_drop,
  output logic [$clog2(QDEPTH):0]  o_ul_level,
  output logic [$clog2(QDEPTH):0]  o_dl_level
);

  localparam int SW  = $clog2(SLOTS);
  localparam int CYW = $clog2(SLOT_CYC);
  localparam int QW  = $clog2(QDEPTH) + 1;
  localparam logic [CYW-1:0] CYC_LAST  = CYW'(SLOT_CYC - 1);
  localparam logic [SW:0]    SLOTS_SAT = (SW + 1)'(SLOTS);

  sched_state_e    state_q, state_d;
  logic [CYW-1:0]  cyc_q, cyc_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [SW:0]     dl_lat_q, dl_lat_d;
  logic            served_q, served_d;
  logic            tx_valid_q, tx_valid_d;
  logic [ID_W-1:0] tx_id_q, tx_id_d;
  logic            dir_q, dir_d;
  logic            frame_start_q, frame_start_d;
  logic            ul_drop_q, ul_drop_d, dl_drop_q, dl_drop_d;
  logic            advance, slot_start, hs;
  logic            push_ul, push_dl, pop_ul, pop_dl;
  logic [ID_W-1:0] ul_head, ul_head_nxt, dl_head, dl_head_nxt;
  logic [QW-1:0]   ul_count, ul_count_nxt, dl_count, dl_count_nxt;
  logic            ul_full, ul_empty, dl_full, dl_empty;

  uldl_id_fifo #(.ID_W(ID_W), .QDEPTH(QDEPTH)) u_ul_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(push_ul), .i_push_id(i_pkt_id), .i_pop(pop_ul),
    .o_head(ul_head), .o_head_nxt(ul_head_nxt), .o_count(ul_count), .o_count_nxt(ul_count_nxt),
    .o_full(ul_full), .o_empty(ul_empty)
  );

  uldl_id_fifo #(.ID_W(ID_W), .QDEPTH(QDEPTH)) u_dl_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(push_dl), .i_push_id(i_pkt_id), .i_pop(pop_dl),
    .o_head(dl_head), .o_head_nxt(dl_head_nxt), .o_count(dl_count), .o_count_nxt(dl_count_nxt),
    .o_full(dl_full), .o_empty(dl_empty)
  );

  // Next-state of slot timing and of every registered output, derived from next-cycle queue state.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    slot_d  = slot_q;
    advance = 1'b0;

    hs      = tx_valid_q & i_tx_ready;
    push_ul = i_pkt_valid & (i_pkt_dir_dl == DIR_UL);
    push_dl = i_pkt_valid & (i_pkt_dir_dl == DIR_DL);
    pop_ul  = hs & (dir_q == DIR_UL) & ~ul_empty;
    pop_dl  = hs & (dir_q == DIR_DL) & ~dl_empty;
    ul_drop_d = push_ul & ul_full & ~pop_ul;
    dl_drop_d = push_dl & dl_full & ~pop_dl;

    case (state_q)
      IDLE: begin
        if (i_ena) begin
          state_d = RUN;
          advance = 1'b1;
          cyc_d   = '0;
          slot_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (i_ena) begin
          advance = 1'b1;
          if (cyc_q == CYC_LAST) begin
            cyc_d  = '0;
            slot_d = slot_q + SW'(1);
          end else begin
            cyc_d  = cyc_q + CYW'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    slot_start    = advance && (cyc_d == '0);
    frame_start_d = slot_start && (slot_d == '0);

    if (frame_start_d) begin
      dl_lat_d = (i_dl_slots > SLOTS_SAT) ? SLOTS_SAT : i_dl_slots;
    end else begin
      dl_lat_d = dl_lat_q;
    end

    if (slot_start) begin
      served_d = 1'b0;
    end else begin
      served_d = served_q | hs;
    end

    dir_d = (state_d == RUN) && ({1'b0, slot_d} < dl_lat_d);

    // While frozen the offer is held; only a completed handshake may withdraw it.
    if (advance) begin
      tx_valid_d = (cyc_d != '0) && !served_d &&
                   (dir_d ? (dl_count_nxt != '0) : (ul_count_nxt != '0));
      tx_id_d    = tx_valid_d ? (dir_d ? dl_head_nxt : ul_head_nxt) : '0;
    end else begin
      tx_valid_d = tx_valid_q & ~hs;
      tx_id_d    = tx_valid_d ? (dir_q ? dl_head : ul_head) : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      slot_q        <= '0;
      dl_lat_q      <= '0;
      served_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_id_q       <= '0;
      dir_q         <= 1'b0;
      frame_start_q <= 1'b0;
      ul_drop_q     <= 1'b0;
      dl_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      slot_q        <= slot_d;
      dl_lat_q      <= dl_lat_d;
      served_q      <= served_d;
      tx_valid_q    <= tx_valid_d;
      tx_id_q       <= tx_id_d;
      dir_q         <= dir_d;
      frame_start_q <= frame_start_d;
      ul_drop_q     <= ul_drop_d;
      dl_drop_q     <= dl_drop_d;
    end
  end

  assign o_tx_valid    = tx_valid_q;
  assign o_tx_id       = tx_id_q;
  assign o_tx_dir_dl   = dir_q;
  assign o_slot_idx    = slot_q;
  assign o_frame_start = frame_start_q;
  assign o_ul_drop     = ul_drop_q;
  assign o_dl_drop     = dl_drop_q;
  assign o_ul_level    = ul_count;
  assign o_dl_level    = dl_count;

endmodule
